// File: rtl/max7219_row_sender.sv
// rtl/max7219_row_sender.sv - MAX7219 frame sender: one-time init words, then 8 row words from an image mux.
// All serial outputs are registered from the next state so they are glitch-free within a phase.
module max7219_row_sender #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] act_add,
  input  logic [7:0] max_in,
  output logic       din,
  output logic       sclk,
  output logic       load,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WORD,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [3:0] FIRST_ROW = 4'd5;
  localparam logic [3:0] LAST_WORD = 4'd12;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic [3:0]  word_q, word_d;
  logic        init_sent_q, init_sent_d;
  logic [2:0]  act_add_q, act_add_d;
  logic        din_q, din_d;
  logic        sclk_q, sclk_d;
  logic        load_q, load_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        phase_end;
  logic [3:0]  row_addr;
  logic [15:0] word_val;

  // Words 0..4 are the init sequence; words 5..12 are rows 0..7 (addr 1..8).
  assign row_addr  = word_q - 4'd4;
  assign phase_end = (div_q == DIV_LAST);

  always_comb begin
    word_val = {4'b0000, row_addr, max_in};
    case (word_q)
      4'd0:    word_val = 16'h0900;
      4'd1:    word_val = 16'h0A08;
      4'd2:    word_val = 16'h0B07;
      4'd3:    word_val = 16'h0C01;
      4'd4:    word_val = 16'h0F00;
      default: word_val = {4'b0000, row_addr, max_in};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    div_d       = 8'd0;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    word_d      = word_q;
    init_sent_d = init_sent_q;
    act_add_d   = act_add_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_WORD;
          word_d  = init_sent_q ? FIRST_ROW : 4'd0;
        end
      end

      LOAD_WORD: begin
        shreg_d = word_val;
        bit_d   = 4'd15;
        state_d = SHIFT_LO;
      end

      SHIFT_LO: begin
        if (phase_end) begin
          state_d = SHIFT_HI;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      SHIFT_HI: begin
        if (phase_end) begin
          if (bit_q == 4'd0) begin
            state_d = LATCH;
          end else begin
            bit_d   = bit_q - 4'd1;
            shreg_d = {shreg_q[14:0], 1'b0};
            state_d = SHIFT_LO;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      LATCH: begin
        if (phase_end) begin
          // Row select moves only here so the mux output settles before the next LOAD_WORD.
          act_add_d = (word_q >= 4'd4 && word_q != LAST_WORD) ? (word_q[2:0] - 3'd4) : 3'd0;
          if (word_q == LAST_WORD) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            init_sent_d = 1'b1;
          end else begin
            word_d  = word_q + 4'd1;
            state_d = LOAD_WORD;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    din_d  = ((state_d == SHIFT_LO) || (state_d == SHIFT_HI)) ? shreg_d[15] : 1'b0;
    sclk_d = (state_d == SHIFT_HI);
    load_d = (state_d == IDLE) || (state_d == LATCH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= 8'd0;
      bit_q       <= 4'd0;
      shreg_q     <= 16'd0;
      word_q      <= 4'd0;
      init_sent_q <= 1'b0;
      act_add_q   <= 3'd0;
      din_q       <= 1'b0;
      sclk_q      <= 1'b0;
      load_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      word_q      <= word_d;
      init_sent_q <= init_sent_d;
      act_add_q   <= act_add_d;
      din_q       <= din_d;
      sclk_q      <= sclk_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign act_add = act_add_q;
  assign din     = din_q;
  assign sclk    = sclk_q;
  assign load    = load_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_max7219_row_sender.sv
// tb/tb_max7219_row_sender.sv - bench for max7219_row_sender with a MAX7219 receiver model and image mux.
`timescale 1ns/1ps
module tb_max7219_row_sender;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start_f = 1'b0;
  logic [2:0] act_add, act_add_f;
  logic [7:0] max_in, max_in_f;
  logic       din, sclk, load, busy, done;
  logic       din_f, sclk_f, load_f, busy_f, done_f;
  logic [7:0] rows [8];

  always #5 clk = ~clk;

  always_comb max_in   = rows[act_add];
  always_comb max_in_f = rows[act_add_f];

  max7219_row_sender #(.CLK_DIV(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .act_add(act_add), .max_in(max_in),
    .din(din), .sclk(sclk), .load(load), .busy(busy), .done(done)
  );

  max7219_row_sender #(.CLK_DIV(1)) u_fast (
    .clk(clk), .reset(reset), .start(start_f), .act_add(act_add_f), .max_in(max_in_f),
    .din(din_f), .sclk(sclk_f), .load(load_f), .busy(busy_f), .done(done_f)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // MAX7219 receiver models: shift din on sclk rise, latch the last 16 bits on load rise.
  logic [15:0] rx_sr = 16'd0, rx_sr_f = 16'd0;
  logic [15:0] rxq[$], rxq_f[$];
  int          rise_f[$];
  logic        sclk_p = 1'b0, load_p = 1'b1, din_p = 1'b0;
  logic        sclk_pf = 1'b0, load_pf = 1'b1, din_pf = 1'b0;
  int          hi_len = 0, hi_len_f = 0, done_cnt = 0, cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (!reset) begin
      if (sclk && !sclk_p) begin
        chk("din_stable_at_sclk_rise", din, din_p);
        rx_sr = {rx_sr[14:0], din};
      end
      if (sclk) hi_len++;
      if (!sclk && sclk_p) chk("sclk_high_len", hi_len, 4);
      if (load && !load_p) rxq.push_back(rx_sr);

      if (sclk_f && !sclk_pf) begin
        chk("fast_din_stable_at_sclk_rise", din_f, din_pf);
        rx_sr_f = {rx_sr_f[14:0], din_f};
      end
      if (sclk_f) hi_len_f++;
      if (!sclk_f && sclk_pf) chk("fast_sclk_high_len", hi_len_f, 1);
      if (load_f && !load_pf) begin
        rxq_f.push_back(rx_sr_f);
        rise_f.push_back(cyc);
      end
    end
    if (!sclk) hi_len = 0;
    if (!sclk_f) hi_len_f = 0;
    sclk_p = sclk;   load_p = load;   din_p = din;
    sclk_pf = sclk_f; load_pf = load_f; din_pf = din_f;
  end

  function automatic void build_expected(input bit with_init, output logic [15:0] q[$]);
    q.delete();
    if (with_init) begin
      q.push_back(16'h0900); q.push_back(16'h0A08); q.push_back(16'h0B07);
      q.push_back(16'h0C01); q.push_back(16'h0F00);
    end
    for (int r = 0; r < 8; r++) q.push_back({4'h0, 4'(r + 1), rows[r]});
  endfunction

  task automatic check_words(input string tag, input logic [15:0] got[$], input bit with_init);
    logic [15:0] expq[$];
    build_expected(with_init, expq);
    chk({tag, "_word_count"}, got.size(), expq.size());
    for (int k = 0; k < expq.size() && k < got.size(); k++)
      chk({tag, "_word"}, got[k], expq[k]);
  endtask

  task automatic launch(input bit hold);
    rxq.delete();
    start = 1'b1;
    @(negedge clk);
    start = hold;
    chk("busy_after_start", busy, 1);
    chk("act_add_first_word", act_add, 0);
  endtask

  task automatic wait_frame(input bit spam, input bit with_init, input int exp_cycles, input bit hold);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (n < exp_cycles + 50) begin
      @(negedge clk);
      n++;
      if (spam) start = ((n % 97) == 5);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = hold;
    chk("frame_done_seen", got, 1);
    chk("frame_cycles", n, exp_cycles);
    chk("busy_low_in_done", busy, 0);
    chk("act_add_idle", act_add, 0);
    check_words("frame", rxq, with_init);
    rxq.delete();
  endtask

  typedef struct {
    bit spam;
    bit rnd;
    bit exp_init;
    int cycles;
  } frame_vec_t;

  frame_vec_t vecs [4];

  initial begin
    int d0;
    int n;
    bit found;
    logic [7:0] pat [8];

    vecs[0] = '{0, 0, 1, 1729};
    vecs[1] = '{0, 0, 0, 1064};
    vecs[2] = '{1, 1, 0, 1064};
    vecs[3] = '{0, 1, 0, 1064};
    pat = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
    for (int r = 0; r < 8; r++) rows[r] = pat[r];

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_din", din, 0);
    chk("rst_done", done, 0);
    chk("rst_act_add", act_add, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].rnd)
        for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
      d0 = done_cnt;
      launch(1'b0);
      wait_frame(vecs[i].spam, vecs[i].exp_init, vecs[i].cycles, 1'b0);
      repeat (300) @(negedge clk);
      chk("one_done_per_frame", done_cnt - d0, 1);
      chk("idle_after_frame", busy, 0);
    end

    // start held through done: second frame follows immediately with no init words
    for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
    launch(1'b1);
    wait_frame(1'b0, 1'b0, 1064, 1'b1);
    @(negedge clk);
    chk("b2b_busy_next_cycle", busy, 1);
    start = 1'b0;
    wait_frame(1'b0, 1'b0, 1064, 1'b0);

    // reset in the middle of row 3's SHIFT_HI
    for (int r = 0; r < 8; r++) rows[r] = 8'($urandom);
    launch(1'b0);
    found = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (act_add == 3'd3 && sclk) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached_row3_shift_hi", found, 1);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_load", load, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_din", din, 0);
    chk("abort_done", done, 0);
    chk("abort_act_add", act_add, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_done_on_abort", done_cnt, d0);
    launch(1'b0);
    wait_frame(1'b0, 1'b1, 1729, 1'b0);

    // CLK_DIV=1 instance: 34-cycle words
    rxq_f.delete();
    rise_f.delete();
    start_f = 1'b1;
    @(negedge clk);
    start_f = 1'b0;
    chk("fast_busy_after_start", busy_f, 1);
    found = 1'b0;
    for (n = 1; n < 500; n++) begin
      @(negedge clk);
      if (done_f) begin
        found = 1'b1;
        break;
      end
    end
    chk("fast_done_seen", found, 1);
    chk("fast_frame_cycles", n, 13 * 34);
    check_words("fast", rxq_f, 1'b1);
    chk("fast_latch_count", rise_f.size(), 13);
    for (int k = 1; k < rise_f.size(); k++)
      chk("fast_word_length", rise_f[k] - rise_f[k-1], 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
